bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Shares one serial double-dabble binary-to-BCD engine between `N_REQ` requesters, such as display, UART and debug sources. It arbitrates round-robin, runs the shift-and-add-3 conversion one bit per clock, and returns the packed BCD result with the winning requester's ID on a single response channel. All requests and responses use valid/ready handshakes with backpressure. It replaces per-requester combinational converters where area matters more than latency.

## Interface
- `N_REQ`, 4: number of requesters; allowed range 2..8.
- `DATA_W`, 8: binary operand width.
- `DIGITS`, 3: BCD digits; must satisfy 10^DIGITS > 2^DATA_W.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_data` in N_REQ*DATA_W: operands; requester i uses bits [i*DATA_W +: DATA_W].
- `req_ready` out N_REQ: one-hot acceptance, or all zero.
- `resp_valid` out 1: a result is available.
- `resp_ready` in 1: downstream accepts the result.
- `resp_id` out $clog2(N_REQ): index of the requester that owns the result.
- `resp_bcd` out 4*DIGITS: packed BCD; the most significant digit is in the top nibble.
- `busy` out 1: high whenever the block is not in IDLE.

## Operation
- States:
  - **IDLE:** waits for a request.
  - **SHIFT:** performs DATA_W iterations.
  - **DONE:** holds the response until accepted.
- **Arbitration:** only in IDLE.
  - `grant` is the first i with `req_valid[i]`=1, searching from `ptr+1` modulo N_REQ.
  - `req_ready[i]` = (state==IDLE) && `rst_n` && grant==i. This is combinational.
  - All `req_ready` bits are 0 in SHIFT and DONE.
- **Accept:** occurs when `req_valid[g]` && `req_ready[g]` at a rising edge.
  - Load the operand shift register with `req_data[g]` and clear the BCD accumulator.
  - Latch `resp_id`=g, set `ptr`=g, set the iteration counter to 0, and go to SHIFT.
- **SHIFT step, each cycle:**
  - For every digit, if digit ≥ 5, add 3. This is a 4-bit add; no carry leaves the nibble.
  - Then shift {bcd, operand} left by 1, with the operand MSB entering the bcd LSB.
  - Increment the counter. After the step with counter==DATA_W-1, go to DONE and set `resp_valid`=1.
- **DONE:**
  - `resp_bcd` and `resp_id` are stable while `resp_valid`=1.
  - On `resp_valid` && `resp_ready`, clear `resp_valid` and go to IDLE.
- **Requester rules:**
  - A requester holds `req_valid` and `req_data` until it sees `req_ready`.
  - Dropping `req_valid` before acceptance is legal and has no effect.
- **Arithmetic:** the full range 0..2^DATA_W-1 is exact; no overflow is possible given the parameter constraint.
- **Reset values:**
  - State is IDLE, `ptr`=N_REQ-1 so requester 0 wins first, and the counter is 0.
  - `resp_valid`=0, `resp_id`=0, `resp_bcd`=0, `busy`=0.
- **Reset mid-operation:** the in-flight conversion is discarded and all outputs take their reset values immediately. No response is produced for the aborted request.

## Timing
- **Accept edge E0.** SHIFT runs at edges E1..E_DATA_W.
- **Response:** `resp_valid` rises after edge E_DATA_W, i.e. DATA_W cycles after acceptance. This is 8 for the default.
- **Back-to-back throughput:** with `resp_ready` tied high the response handshake takes one cycle, and IDLE takes one cycle before the next accept. Throughput is one conversion per DATA_W+2 cycles (10 by default).
- **No overlap:** a new request is never accepted in the same cycle as a response handshake.
- **Backpressure:** `resp_ready` low holds DONE indefinitely, with no output change and `req_ready` all zero.
- **`busy`:** goes high the cycle after acceptance and low the cycle after the response handshake.

## Structure
- **Shared package `bcd_ctrl_pkg`:**
  - state enum {IDLE, SHIFT, DONE}
  - function `add3_digits(bcd)`, which applies the per-nibble ≥5 → +3 correction
  - default constants for DATA_W and DIGITS
- **Sub-module `bcd_dd_serial`:** the operand/BCD shift register plus iteration counter.
  - Inputs: `load`, `din`, `step`.
  - Outputs: `bcd`, `last`.
- **Top level:** holds the round-robin arbiter, the FSM and the response register.

## Test plan
- **Single request:** `req_valid`=4'b0001, data 8'd255 → one `req_ready[0]` pulse; 8 cycles later `resp_valid`=1, `resp_bcd`=12'h255, `resp_id`=0.
- **All requesters at once:** all four valid with data 10, 20, 30 and 40, `resp_ready`=1 → responses in ID order 0,1,2,3 with BCD 0x010, 0x020, 0x030, 0x040, spaced 10 cycles apart.
- **Fairness:** requesters 0 and 2 continuously valid → grants alternate 0,2,0,2; requesters 1 and 3 never receive `req_ready`.
- **Backpressure:** `resp_ready`=0 for 5 cycles in DONE → `resp_valid`, `resp_bcd` and `resp_id` stable, `req_ready`=0 throughout; on release, one handshake, then IDLE.
- **Reset mid-conversion:** assert `rst_n`=0 at iteration 4 → outputs go to reset values immediately and no response appears. After release, a request with 8'd99 → 12'h099 from requester 0.
- **Exhaustive check:** inputs 0..255 through requester 3 → every `resp_bcd` matches the reference model, e.g. 0 → 12'h000 and 128 → 12'h128.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the shared serial binary-to-BCD converter.
// Contents:
//   state_t      - controller states (IDLE, SHIFT, DONE)
//   DATA_W_DEF   - default binary operand width
//   DIGITS_DEF   - default number of BCD digits
//   MAX_DIGITS   - widest BCD accumulator the helper function supports
//   add3_digits  - double-dabble correction: every nibble >= 5 gets +3
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DIGITS_DEF = 3;
  localparam int MAX_DIGITS = 10;
  localparam int MAX_BCD_W  = 4 * MAX_DIGITS;

  // Callers zero-extend their accumulator to MAX_BCD_W; zero nibbles are
  // never corrected, so the unused upper part stays zero.
  function automatic logic [MAX_BCD_W-1:0] add3_digits(input logic [MAX_BCD_W-1:0] bcd);
    logic [MAX_BCD_W-1:0] r;
    r = bcd;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bus of the shared BCD converter.
//   req_valid[N_REQ]        requester -> converter, per-requester valid
//   req_data[N_REQ*DATA_W]  requester -> converter, operand i at [i*DATA_W +: DATA_W]
//   req_ready[N_REQ]        converter -> requester, one-hot acceptance or zero
//   resp_valid/resp_ready   response handshake
//   resp_id                 index of the requester owning the result
//   resp_bcd                packed BCD, most significant digit in the top nibble
//   busy                    converter is not idle
// Modports: master = requester/consumer side, slave = converter.
interface bcd_conv_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [ID_W-1:0]         resp_id;
  logic [4*DIGITS-1:0]     resp_bcd;
  logic                    busy;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_bcd, busy
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_bcd, busy
  );
endinterface

// File: rtl/bcd_dd_serial.sv
// Serial double-dabble datapath: operand shift register, BCD accumulator
// and iteration counter. One bit of the operand is consumed per step.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      capture din_i, clear accumulator and counter
//   din_i       binary operand
//   step_i      perform one correct-then-shift iteration
//   bcd_o       current BCD accumulator
//   last_o      counter is at the final iteration (DATA_W-1)
module bcd_dd_serial
  import bcd_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   din_i,
  input  logic                step_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                last_o
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]    op_q, op_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAX_BCD_W-1:0] bcd_wide;
  logic [MAX_BCD_W-1:0] bcd_corr;

  always_comb begin
    bcd_wide              = '0;
    bcd_wide[BCD_W-1:0]   = bcd_q;
    bcd_corr              = add3_digits(bcd_wide);
    op_d                  = op_q;
    bcd_d                 = bcd_q;
    cnt_d                 = cnt_q;
    if (load_i) begin
      op_d  = din_i;
      bcd_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      // Corrected accumulator shifts left with the operand MSB entering bit 0.
      bcd_d = BCD_W'({bcd_corr, op_q[DATA_W-1]});
      op_d  = {op_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one serial double-dabble converter among N_REQ requesters.
// Round-robin arbitration in IDLE, DATA_W shift steps in SHIFT, result
// held in DONE until the consumer accepts it.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_conv_arbiter_if.slave (requests, response, busy)
module bcd_conv_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_conv_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     resp_id_q;
  logic                resp_valid_q;
  logic                busy_q;

  logic [ID_W-1:0]     grant;
  logic                grant_vld;
  logic [N_REQ-1:0]    ready;
  logic                accept;
  logic                step;
  logic                last;
  logic [DATA_W-1:0]   din;
  logic [4*DIGITS-1:0] bcd;

  // Scan from farthest to nearest after ptr so the nearest valid requester
  // is the last one written and therefore wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (bus.req_valid[idx]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    if ((state_q == IDLE) && rst_n && grant_vld) begin
      ready[grant] = 1'b1;
    end
  end

  assign accept = |(bus.req_valid & ready);
  assign step   = (state_q == SHIFT);
  assign din    = bus.req_data[int'(grant)*DATA_W +: DATA_W];

  bcd_dd_serial #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .din_i  (din),
    .step_i (step),
    .bcd_o  (bcd),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(N_REQ - 1);
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SHIFT;
            ptr_q     <= grant;
            resp_id_q <= grant;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (last) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Always returns through IDLE, so a new accept never coincides
          // with the response handshake.
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_bcd   = bcd;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Testbench for bcd_conv_arbiter: directed requests with hand-computed BCD
// results queued in a scoreboard; a monitor compares every response handshake.
module tb_bcd_conv_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int DIGITS = 3;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] bcd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

  bcd_conv_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb[$];
  logic [7:0] opq[4][$];
  int         hs_cyc[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         bad_ready = 0;
  logic       watch_fair = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester driver: each requester presents the head of its operand queue
  // and pops it once accepted.
  initial begin
    logic [3:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        bus.req_valid[i]        = (opq[i].size() > 0);
        bus.req_data[i*8 +: 8]  = (opq[i].size() > 0) ? opq[i][0] : 8'd0;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_valid && bus.resp_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got id=%0d bcd=0x%0h expected no response",
                   bus.resp_id, bus.resp_bcd);
        end else begin
          e = sb.pop_front();
          check("resp_id", 32'(bus.resp_id), 32'(e.id));
          check("resp_bcd", 32'(bus.resp_bcd), 32'(e.bcd));
        end
      end
      if (watch_fair && (bus.req_ready[1] || bus.req_ready[3])) bad_ready++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int i, output int c);
    c = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        c = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_ready%0d: got timeout expected req_ready", i);
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        c = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: got timeout expected resp_valid");
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.resp_valid && !bus.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL drain: got %0d pending responses expected 0", sb.size());
  endtask

  initial begin
    int rc, vc;
    rst_n          = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_resp_bcd", 32'(bus.resp_bcd), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;

    // Single request, 255 from requester 0
    sb.push_back('{id: 2'd0, bcd: 12'h255});
    opq[0].push_back(8'd255);
    wait_ready(0, rc);
    check("first_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    check("ready_pulse", 32'(bus.req_ready), 0);
    check("busy_after_accept", 32'(bus.busy), 1);
    wait_valid(vc);
    check("latency", 32'(vc - rc - 1), 8);
    drain(100);

    // All four at once: ID order, 10-cycle spacing
    do_reset();
    hs_cyc.delete();
    sb.push_back('{id: 2'd0, bcd: 12'h010});
    sb.push_back('{id: 2'd1, bcd: 12'h020});
    sb.push_back('{id: 2'd2, bcd: 12'h030});
    sb.push_back('{id: 2'd3, bcd: 12'h040});
    opq[0].push_back(8'd10);
    opq[1].push_back(8'd20);
    opq[2].push_back(8'd30);
    opq[3].push_back(8'd40);
    drain(200);
    check("all_hs_count", 32'(hs_cyc.size()), 4);
    if (hs_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("hs_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 10);
    end

    // Fairness between requesters 0 and 2
    do_reset();
    watch_fair = 1'b1;
    bad_ready  = 0;
    sb.push_back('{id: 2'd0, bcd: 12'h011});
    sb.push_back('{id: 2'd2, bcd: 12'h021});
    sb.push_back('{id: 2'd0, bcd: 12'h012});
    sb.push_back('{id: 2'd2, bcd: 12'h022});
    opq[0].push_back(8'd11);
    opq[0].push_back(8'd12);
    opq[2].push_back(8'd21);
    opq[2].push_back(8'd22);
    drain(200);
    watch_fair = 1'b0;
    check("fair_ready_1_3", 32'(bad_ready), 0);

    // Backpressure in DONE with another requester waiting
    do_reset();
    bus.resp_ready = 1'b0;
    sb.push_back('{id: 2'd0, bcd: 12'h077});
    opq[0].push_back(8'd77);
    wait_valid(vc);
    sb.push_back('{id: 2'd1, bcd: 12'h005});
    opq[1].push_back(8'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.resp_valid), 1);
      check("bp_bcd", 32'(bus.resp_bcd), 32'h077);
      check("bp_id", 32'(bus.resp_id), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("bp_idle_valid", 32'(bus.resp_valid), 0);
    check("bp_idle_busy", 32'(bus.busy), 0);
    check("bp_idle_grant", 32'(bus.req_ready), 32'h2);
    drain(100);

    // Reset during iteration 4 of a conversion for requester 2
    do_reset();
    opq[2].push_back(8'd200);
    wait_ready(2, rc);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(bus.busy), 1);
    check("pre_rst_id", 32'(bus.resp_id), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.resp_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_bcd", 32'(bus.resp_bcd), 0);
    check("mid_rst_id", 32'(bus.resp_id), 0);
    check("mid_rst_ready", 32'(bus.req_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    sb.push_back('{id: 2'd0, bcd: 12'h099});
    opq[0].push_back(8'd99);
    drain(100);

    // Every operand through requester 3
    do_reset();
    for (int v = 0; v < 256; v++) begin
      opq[3].push_back(8'(v));
      sb.push_back('{id: 2'd3, bcd: ref_bcd(v)});
    end
    drain(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
